fp_align_norm_ctrl: RTL

- Sequencer for the mini floating-point adder. Accepts two operands and orders them by magnitude.
- Drives the 8-bit barrel shifter to align the smaller significand, then adds or subtracts.
- Normalizes the result: one right shift on carry-out, or iterative 1-bit left shifts, one per cycle.
- Sits between the operand source and result sink via valid/ready handshakes; one operation in flight at a time.

---
 rtl/fp_align_norm_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fp_align_norm_ctrl.sv
// rtl/fp_align_norm_ctrl.sv - mini floating-point adder sequencer: compare, align, add, normalize
module fp_align_norm_ctrl #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op_sub,
   input  logic [EXP_W+MAN_W:0] in_a,
   input  logic [EXP_W+MAN_W:0] in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_res,
   output logic                 ovf,
   output logic                 uf
);
   localparam int W = 1 + EXP_W + MAN_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMP,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [W-1:0]     a_q, b_q;
   logic             sign_q, eff_sub_q;
   logic [EXP_W-1:0] exp_q, diff_q;
   logic [MAN_W-1:0] mant_l_q, mant_s_q, aligned_q;
   logic [MAN_W:0]   sum_q;
   logic [W-1:0]     res_q;
   logic             ovf_q, uf_q, out_valid_q;

   logic             a_ge_b, diff_big;
   logic             norm_done, norm_ovf, norm_uf;
   logic [W-1:0]     norm_res;

   // {exp, mant} sits contiguously below the sign, so one compare orders by magnitude
   assign a_ge_b   = a_q[W-2:0] >= b_q[W-2:0];
   assign diff_big = int'(diff_q) >= MAN_W;

   always_comb begin
      norm_done = 1'b1;
      norm_ovf  = 1'b0;
      norm_uf   = 1'b0;
      norm_res  = '0;
      if (sum_q == '0) begin
         norm_res = '0;
      end else if (sum_q[MAN_W]) begin
         if (&exp_q) begin
            norm_ovf = 1'b1;
            norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
         end else begin
            norm_res = {sign_q, exp_q + EXP_W'(1), sum_q[MAN_W:1]};
         end
      end else if (sum_q[MAN_W-1]) begin
         norm_res = {sign_q, exp_q, sum_q[MAN_W-1:0]};
      end else if (exp_q == '0) begin
         norm_uf = 1'b1;
      end else begin
         norm_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (in_valid) state_d = S_CMP;
         S_CMP:   state_d = S_ALIGN;
         S_ALIGN: state_d = S_ADD;
         S_ADD:   state_d = S_NORM;
         S_NORM:  if (norm_done) state_d = S_DONE;
         S_DONE:  if (out_valid_q && out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = out_valid_q;
      out_res   = res_q;
      ovf       = ovf_q;
      uf        = uf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         sign_q      <= 1'b0;
         eff_sub_q   <= 1'b0;
         exp_q       <= '0;
         diff_q      <= '0;
         mant_l_q    <= '0;
         mant_s_q    <= '0;
         aligned_q   <= '0;
         sum_q       <= '0;
         res_q       <= '0;
         ovf_q       <= 1'b0;
         uf_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= {in_b[W-1] ^ op_sub, in_b[W-2:0]};
                  ovf_q <= 1'b0;
                  uf_q  <= 1'b0;
               end
            end
            S_CMP: begin
               eff_sub_q <= a_q[W-1] ^ b_q[W-1];
               if (a_ge_b) begin
                  sign_q   <= a_q[W-1];
                  exp_q    <= a_q[W-2:MAN_W];
                  mant_l_q <= a_q[MAN_W-1:0];
                  mant_s_q <= b_q[MAN_W-1:0];
                  diff_q   <= a_q[W-2:MAN_W] - b_q[W-2:MAN_W];
               end else begin
                  sign_q   <= b_q[W-1];
                  exp_q    <= b_q[W-2:MAN_W];
                  mant_l_q <= b_q[MAN_W-1:0];
                  mant_s_q <= a_q[MAN_W-1:0];
                  diff_q   <= b_q[W-2:MAN_W] - a_q[W-2:MAN_W];
               end
            end
            S_ALIGN: aligned_q <= diff_big ? '0 : (mant_s_q >> diff_q);
            S_ADD: begin
               sum_q <= eff_sub_q ? ({1'b0, mant_l_q} - {1'b0, aligned_q})
                                  : ({1'b0, mant_l_q} + {1'b0, aligned_q});
            end
            S_NORM: begin
               if (norm_done) begin
                  res_q <= norm_res;
                  ovf_q <= norm_ovf;
                  uf_q  <= norm_uf;
               end else begin
                  sum_q <= sum_q << 1;
                  exp_q <= exp_q - EXP_W'(1);
               end
            end
            // first DONE cycle publishes the result; the handshake then retires it
            S_DONE: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
